// File: rtl/reorder_buffer_pkg.sv
// Shared constants and tag/index helpers for the reorder buffer.
// Tags are entry index + 1 so that tag 0 can mean "no dependency".
package reorder_buffer_pkg;

  localparam int unsigned RobDepth = 8;
  localparam int unsigned RobTagW  = 4;

  localparam logic [RobTagW-1:0] TagNone = '0;

  function automatic int unsigned idx_to_tag(input int unsigned idx);
    return idx + 1;
  endfunction

  // Only meaningful for tag != TagNone.
  function automatic int unsigned tag_to_idx(input int unsigned tag);
    return tag - 1;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order commit buffer: allocates rename tags, captures CDB results,
// retires the head entry in program order and answers operand-bypass queries.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = RobDepth,
  parameter int unsigned TAG_W = RobTagW
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  input  logic             alloc_done,
  input  logic [31:0]      alloc_data,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  input  logic [TAG_W-1:0] qry_tag_j,
  input  logic [TAG_W-1:0] qry_tag_k,
  output logic             qry_ok_j,
  output logic [31:0]      qry_data_j,
  output logic             qry_ok_k,
  output logic [31:0]      qry_data_k,
  output logic             commit_valid,
  output logic [TAG_W-1:0] commit_tag,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [4:0]       rd_q   [DEPTH];
  logic [4:0]       rd_d   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];

  logic [IdxW-1:0] head_q, head_d;
  logic [IdxW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic             commit_valid_q, commit_valid_d;
  logic [TAG_W-1:0] commit_tag_q, commit_tag_d;
  logic [4:0]       commit_rd_q, commit_rd_d;
  logic [31:0]      commit_data_q, commit_data_d;

  logic             alloc_fire;
  logic             commit_fire;
  logic [DEPTH-1:0] cdb_hit;

  function automatic logic [IdxW-1:0] ptr_inc(input logic [IdxW-1:0] p);
    return (p == LastIdx) ? '0 : p + 1'b1;
  endfunction

  assign full        = (count_q == FullCnt);
  assign empty       = (count_q == '0);
  assign alloc_ready = !full;
  assign alloc_tag   = TAG_W'(idx_to_tag(32'(tail_q)));

  // Full gating uses the pre-edge count: a same-cycle commit never frees a slot.
  assign alloc_fire  = alloc_valid && !full;
  assign commit_fire = busy_q[head_q] && done_q[head_q];

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cdb_hit[i] = cdb_valid && (cdb_tag != TAG_W'(TagNone)) &&
                   (cdb_tag == TAG_W'(idx_to_tag(i))) && busy_q[i];
    end
  end

  // Tag 0 never matches since every entry's tag is index + 1.
  always_comb begin
    qry_ok_j   = 1'b0;
    qry_data_j = '0;
    qry_ok_k   = 1'b0;
    qry_data_k = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((qry_tag_j == TAG_W'(idx_to_tag(i))) && busy_q[i] && done_q[i]) begin
        qry_ok_j   = 1'b1;
        qry_data_j = data_q[i];
      end
      if ((qry_tag_k == TAG_W'(idx_to_tag(i))) && busy_q[i] && done_q[i]) begin
        qry_ok_k   = 1'b1;
        qry_data_k = data_q[i];
      end
    end
  end

  always_comb begin
    busy_d         = busy_q;
    done_d         = done_q;
    rd_d           = rd_q;
    data_d         = data_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = commit_valid_q;
    commit_tag_d   = commit_tag_q;
    commit_rd_d    = commit_rd_q;
    commit_data_d  = commit_data_q;

    if (flush_in) begin
      busy_d         = '0;
      done_d         = '0;
      head_d         = '0;
      tail_d         = '0;
      count_d        = '0;
      commit_valid_d = 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (cdb_hit[i]) begin
          done_d[i] = 1'b1;
          data_d[i] = cdb_data;
        end
      end

      if (alloc_fire) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = alloc_done;
        rd_d[tail_q]   = alloc_rd;
        data_d[tail_q] = alloc_data;
        tail_d         = ptr_inc(tail_q);
      end

      // Retirement clears last so it wins over a stray CDB to the retiring tag.
      commit_valid_d = commit_fire;
      if (commit_fire) begin
        commit_tag_d   = TAG_W'(idx_to_tag(32'(head_q)));
        commit_rd_d    = rd_q[head_q];
        commit_data_d  = data_q[head_q];
        busy_d[head_q] = 1'b0;
        done_d[head_q] = 1'b0;
        head_d         = ptr_inc(head_q);
      end

      count_d = count_q + CntW'(alloc_fire) - CntW'(commit_fire);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q         <= '0;
      done_q         <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_tag_q   <= '0;
      commit_rd_q    <= '0;
      commit_data_q  <= '0;
    end else if (rdy_in) begin
      busy_q         <= busy_d;
      done_q         <= done_d;
      rd_q           <= rd_d;
      data_q         <= data_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_tag_q   <= commit_tag_d;
      commit_rd_q    <= commit_rd_d;
      commit_data_q  <= commit_data_d;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_tag   = commit_tag_q;
  assign commit_rd    = commit_rd_q;
  assign commit_data  = commit_data_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based program-order model.
module tb_reorder_buffer;

  localparam int Depth = 8;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        flush_in = 1'b0;
  logic        alloc_valid = 1'b0;
  logic [4:0]  alloc_rd = '0;
  logic        alloc_done = 1'b0;
  logic [31:0] alloc_data = '0;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_tag = '0;
  logic [31:0] cdb_data = '0;
  logic [3:0]  qry_tag_j = '0;
  logic [3:0]  qry_tag_k = '0;
  logic        qry_ok_j, qry_ok_k;
  logic [31:0] qry_data_j, qry_data_k;
  logic        commit_valid;
  logic [3:0]  commit_tag;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic        empty, full;

  reorder_buffer #(.DEPTH(8), .TAG_W(4)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .flush_in    (flush_in),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .alloc_done  (alloc_done),
    .alloc_data  (alloc_data),
    .alloc_ready (alloc_ready),
    .alloc_tag   (alloc_tag),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .qry_tag_j   (qry_tag_j),
    .qry_tag_k   (qry_tag_k),
    .qry_ok_j    (qry_ok_j),
    .qry_data_j  (qry_data_j),
    .qry_ok_k    (qry_ok_k),
    .qry_data_k  (qry_data_k),
    .commit_valid(commit_valid),
    .commit_tag  (commit_tag),
    .commit_rd   (commit_rd),
    .commit_data (commit_data),
    .empty       (empty),
    .full        (full)
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: in-flight tags in program order, plus per-tag payload.
  int          order_q[$];
  bit          m_done[16];
  logic [4:0]  m_rd[16];
  logic [31:0] m_data[16];
  int          next_tag;
  bit          m_cv;
  int          m_ctag;
  logic [4:0]  m_crd;
  logic [31:0] m_cdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_flight(input int t);
    foreach (order_q[i]) if (order_q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    order_q.delete();
    for (int i = 0; i < 16; i++) m_done[i] = 1'b0;
    next_tag = 1;
    m_cv     = 1'b0;
    m_ctag   = 0;
    m_crd    = '0;
    m_cdata  = '0;
  endfunction

  function automatic void model_step();
    int  sz;
    int  ht;
    int  ct;
    bit  com;
    sz = order_q.size();
    if (flush_in) begin
      order_q.delete();
      next_tag = 1;
      m_cv     = 1'b0;
      return;
    end
    ht  = (sz > 0) ? order_q[0] : 0;
    com = (sz > 0) && m_done[ht];
    if (com) begin
      m_cv    = 1'b1;
      m_ctag  = ht;
      m_crd   = m_rd[ht];
      m_cdata = m_data[ht];
    end else begin
      m_cv = 1'b0;
    end
    ct = int'(cdb_tag);
    if (cdb_valid && ct != 0 && in_flight(ct) && !(com && ct == ht)) begin
      m_done[ct] = 1'b1;
      m_data[ct] = cdb_data;
    end
    if (com) begin
      void'(order_q.pop_front());
      m_done[ht] = 1'b0;
    end
    if (alloc_valid && sz < Depth) begin
      order_q.push_back(next_tag);
      m_done[next_tag] = alloc_done;
      m_rd[next_tag]   = alloc_rd;
      m_data[next_tag] = alloc_data;
      next_tag = (next_tag == Depth) ? 1 : next_tag + 1;
    end
  endfunction

  function automatic bit exp_ok(input logic [3:0] t);
    return (t != 0) && in_flight(int'(t)) && m_done[t];
  endfunction

  function automatic logic [31:0] exp_data(input logic [3:0] t);
    return exp_ok(t) ? m_data[t] : 32'h0;
  endfunction

  always @(negedge rst_in) model_reset();

  always @(posedge clk_in) if (rst_in && rdy_in) model_step();

  // Per-cycle comparison against the model.
  always @(negedge clk_in) begin
    chk("commit_valid", 32'(commit_valid), 32'(m_cv));
    chk("commit_tag", 32'(commit_tag), 32'(m_ctag));
    chk("commit_rd", 32'(commit_rd), 32'(m_crd));
    chk("commit_data", commit_data, m_cdata);
    chk("empty", 32'(empty), 32'(order_q.size() == 0));
    chk("full", 32'(full), 32'(order_q.size() == Depth));
    chk("alloc_ready", 32'(alloc_ready), 32'(order_q.size() < Depth));
    chk("alloc_tag", 32'(alloc_tag), 32'(next_tag));
    chk("qry_ok_j", 32'(qry_ok_j), 32'(exp_ok(qry_tag_j)));
    chk("qry_data_j", qry_data_j, exp_data(qry_tag_j));
    chk("qry_ok_k", 32'(qry_ok_k), 32'(exp_ok(qry_tag_k)));
    chk("qry_data_k", qry_data_k, exp_data(qry_tag_k));
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_flush();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
  endtask

  task automatic do_alloc(input logic [4:0] rd, input logic dn, input logic [31:0] d);
    alloc_valid = 1'b1;
    alloc_rd    = rd;
    alloc_done  = dn;
    alloc_data  = d;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic do_cdb(input logic [3:0] t, input logic [31:0] d);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_data  = d;
    tick();
    cdb_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    #12 rst_in = 1'b1;
    tick();

    // Basic alloc, CDB, commit latency.
    chk("t1_alloc_tag", 32'(alloc_tag), 32'd1);
    chk("t1_empty0", 32'(empty), 32'd1);
    do_alloc(5'd5, 1'b0, 32'h0);
    chk("t1_not_empty", 32'(empty), 32'd0);
    chk("t1_alloc_tag2", 32'(alloc_tag), 32'd2);
    do_cdb(4'd1, 32'hDEADBEEF);
    chk("t1_no_commit_yet", 32'(commit_valid), 32'd0);
    tick();
    chk("t1_commit_valid", 32'(commit_valid), 32'd1);
    chk("t1_commit_tag", 32'(commit_tag), 32'd1);
    chk("t1_commit_rd", 32'(commit_rd), 32'd5);
    chk("t1_commit_data", commit_data, 32'hDEADBEEF);
    chk("t1_empty", 32'(empty), 32'd1);

    // Out-of-order completion retires in tag order.
    do_flush();
    for (int i = 1; i <= 3; i++) do_alloc(5'(i + 10), 1'b0, 32'h0);
    do_cdb(4'd3, 32'h33);
    do_cdb(4'd2, 32'h22);
    do_cdb(4'd1, 32'h11);
    tick();
    chk("t2_c1_tag", 32'(commit_tag), 32'd1);
    chk("t2_c1_data", commit_data, 32'h11);
    tick();
    chk("t2_c2_tag", 32'(commit_tag), 32'd2);
    chk("t2_c2_valid", 32'(commit_valid), 32'd1);
    tick();
    chk("t2_c3_tag", 32'(commit_tag), 32'd3);
    chk("t2_c3_data", commit_data, 32'h33);
    tick();
    chk("t2_idle", 32'(commit_valid), 32'd0);

    // Full, ignored ninth alloc, wrap.
    do_flush();
    for (int i = 0; i < 8; i++) do_alloc(5'(i), 1'b0, 32'h0);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_alloc_ready", 32'(alloc_ready), 32'd0);
    do_alloc(5'd9, 1'b1, 32'h99);
    chk("t3_still_full", 32'(full), 32'd1);
    chk("t3_tag_wrap", 32'(alloc_tag), 32'd1);
    do_cdb(4'd1, 32'hA1);
    alloc_valid = 1'b1;
    alloc_rd    = 5'd31;
    alloc_done  = 1'b0;
    tick();
    chk("t3_commit_tag", 32'(commit_tag), 32'd1);
    chk("t3_no_same_cycle_alloc", 32'(full), 32'd0);
    chk("t3_wrap_tag", 32'(alloc_tag), 32'd1);
    tick();
    alloc_valid = 1'b0;
    chk("t3_refull", 32'(full), 32'd1);
    chk("t3_next_tag", 32'(alloc_tag), 32'd2);

    // alloc_done entry and query bypass.
    do_flush();
    do_alloc(5'd7, 1'b1, 32'h1000);
    qry_tag_j = 4'd1;
    qry_tag_k = 4'd2;
    #1;
    chk("t4_qry_ok_j", 32'(qry_ok_j), 32'd1);
    chk("t4_qry_data_j", qry_data_j, 32'h1000);
    chk("t4_qry_ok_k", 32'(qry_ok_k), 32'd0);
    tick();
    chk("t4_commit", 32'(commit_valid), 32'd1);
    chk("t4_commit_data", commit_data, 32'h1000);
    chk("t4_qry_gone", 32'(qry_ok_j), 32'd0);
    chk("t4_qry_data0", qry_data_j, 32'h0);
    qry_tag_j = '0;
    qry_tag_k = '0;

    // Flush with coincident CDB.
    for (int i = 0; i < 4; i++) do_alloc(5'(i + 1), 1'b0, 32'h0);
    flush_in  = 1'b1;
    cdb_valid = 1'b1;
    cdb_tag   = 4'd3;
    cdb_data  = 32'h5A5A;
    tick();
    flush_in  = 1'b0;
    cdb_valid = 1'b0;
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_cv", 32'(commit_valid), 32'd0);
    chk("t5_tag", 32'(alloc_tag), 32'd1);
    do_cdb(4'd2, 32'h77);
    qry_tag_j = 4'd2;
    #1;
    chk("t5_cdb_ignored", 32'(qry_ok_j), 32'd0);
    tick();
    chk("t5_still_empty", 32'(empty), 32'd1);
    chk("t5_no_commit", 32'(commit_valid), 32'd0);
    qry_tag_j = '0;

    // Freeze with a done head.
    do_flush();
    do_alloc(5'd3, 1'b1, 32'h55);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_frozen_cv", 32'(commit_valid), 32'd0);
      chk("t6_frozen_tag", 32'(alloc_tag), 32'd2);
    end
    rdy_in = 1'b1;
    tick();
    chk("t6_resume_cv", 32'(commit_valid), 32'd1);
    chk("t6_resume_data", commit_data, 32'h55);
    chk("t6_resume_empty", 32'(empty), 32'd1);

    // Asynchronous reset mid-cycle.
    #2 rst_in = 1'b0;
    #1;
    chk("t7_rst_cv", 32'(commit_valid), 32'd0);
    chk("t7_rst_tag", 32'(commit_tag), 32'd0);
    chk("t7_rst_rd", 32'(commit_rd), 32'd0);
    chk("t7_rst_data", commit_data, 32'h0);
    chk("t7_rst_alloc_tag", 32'(alloc_tag), 32'd1);
    #3 rst_in = 1'b1;
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rdy_in      = ($urandom_range(0, 9) != 0);
      flush_in    = ($urandom_range(0, 59) == 0);
      alloc_valid = ($urandom_range(0, 4) < 3);
      alloc_rd    = 5'($urandom_range(0, 31));
      alloc_done  = ($urandom_range(0, 3) == 0);
      alloc_data  = $urandom;
      cdb_valid   = ($urandom_range(0, 2) != 0);
      cdb_data    = $urandom;
      if (order_q.size() > 0 && $urandom_range(0, 7) != 0)
        cdb_tag = 4'(order_q[$urandom_range(0, order_q.size() - 1)]);
      else
        cdb_tag = 4'($urandom_range(0, 15));
      if (order_q.size() > 0 && $urandom_range(0, 3) != 0)
        qry_tag_j = 4'(order_q[$urandom_range(0, order_q.size() - 1)]);
      else
        qry_tag_j = 4'($urandom_range(0, 15));
      qry_tag_k = 4'($urandom_range(0, 15));
      tick();
    end

    rdy_in      = 1'b1;
    flush_in    = 1'b0;
    alloc_valid = 1'b0;
    cdb_valid   = 1'b0;
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
